fetch_buf: RTL and testbench

Parametrised instruction-fetch stage with a prefetch buffer. It generates sequential fetch addresses to instruction memory, which has a fixed one-cycle response latency. Returned words are held with their PC in a DEPTH-entry FIFO, which supplies decode through a valid/stall handshake. A taken branch redirects the fetch PC, flushes the buffer and discards any response already in flight.

---
 rtl/fetch_buf.sv | 94 +++++++++
 tb/tb_fetch_buf.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buf.sv
// Instruction-fetch stage: issues sequential word fetches under a credit limit and
// buffers the one-cycle-latency responses in a DEPTH-entry FIFO toward decode.
module fetch_buf #(
    parameter int unsigned     WORD     = 32,
    parameter int unsigned     ADDR     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_o,
    output logic [ADDR-1:0] addr_o,
    input  logic            v_i,
    input  logic [WORD-1:0] inst_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] baddr_i,
    output logic            v_o,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] pc_o,
    input  logic            stall_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR-1:0] r_fetch_pc;
    logic [ADDR-1:0] r_inflight_pc;
    logic            r_inflight;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [ADDR-1:0] r_pc_mem   [DEPTH];
    logic [WORD-1:0] r_inst_mem [DEPTH];

    logic            w_flush;
    logic [CW:0]     w_used;
    logic            w_credit;
    logic            w_req;
    logic            w_write;
    logic            w_deq;

    // Reset behaves exactly like a redirect to RESET_PC.
    assign w_flush  = rst | branch_i;
    // Credit uses registered occupancy only, so a same-cycle dequeue frees nothing.
    assign w_used   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit = w_used < (CW + 1)'(DEPTH);
    assign w_req    = ~w_flush & w_credit;
    // A missing response to a live request is simply lost.
    assign w_write  = ~w_flush & r_inflight & v_i;
    assign w_deq    = v_o & ~stall_i;

    always_comb begin
        req_o  = w_req;
        addr_o = r_fetch_pc;
        v_o    = (r_count != '0);
        inst_o = r_inst_mem[r_rd_ptr];
        pc_o   = r_pc_mem[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_fetch_pc    <= rst ? RESET_PC : baddr_i;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            if (w_req) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 1'b1;
            end else begin
                r_inflight    <= 1'b0;
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_write) - CW'(w_deq);
        end
    end

    // Storage needs no reset: the head is only meaningful while v_o is high.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
            r_inst_mem[r_wr_ptr] <= inst_i;
        end
    end

endmodule

// File: tb/tb_fetch_buf.sv
// Bench for fetch_buf: directed table, hand-written corner sequences and random traffic,
// all checked against a queue-based reference model of the fetch stage.
module tb_fetch_buf;

    localparam int unsigned WORD   = 32;
    localparam int unsigned ADDR   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_o;
    logic [31:0] addr_o;
    logic        v_i;
    logic [31:0] inst_i;
    logic        branch_i;
    logic [31:0] baddr_i;
    logic        v_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        stall_i;

    fetch_buf #(
        .WORD    (WORD),
        .ADDR    (ADDR),
        .DEPTH   (DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_o   (req_o),
        .addr_o  (addr_o),
        .v_i     (v_i),
        .inst_i  (inst_i),
        .branch_i(branch_i),
        .baddr_i (baddr_i),
        .v_o     (v_o),
        .inst_o  (inst_o),
        .pc_o    (pc_o),
        .stall_i (stall_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    // Reference model state: buffered words, outstanding request, next fetch address.
    ent_t        q[$];
    logic        m_inflight    = 1'b0;
    logic [31:0] m_inflight_pc = '0;
    logic [31:0] m_fetch_pc    = RST_PC;
    logic        m_req_prev    = 1'b0;
    logic [31:0] m_addr_prev   = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic        s_req, s_v;
    logic [31:0] s_addr, s_pc, s_inst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, let memory answer last cycle's request, compare, advance.
    task automatic step(input logic r, input logic b, input logic [31:0] ba, input logic st,
                        input logic drop, input logic spur);
        logic e_req, e_v;
        rst      = r;
        branch_i = b;
        baddr_i  = ba;
        stall_i  = st;
        v_i      = (m_req_prev & ~drop) | (~m_req_prev & spur);
        inst_i   = m_req_prev ? (m_addr_prev ^ KEY) : $urandom;
        #4;
        e_req  = !r && !b && ((q.size() + int'(m_inflight)) < int'(DEPTH));
        e_v    = (q.size() != 0);
        s_req  = req_o;
        s_addr = addr_o;
        s_v    = v_o;
        s_pc   = pc_o;
        s_inst = inst_o;
        chk("req_o", {31'b0, s_req}, {31'b0, e_req});
        if (e_req) chk("addr_o", s_addr, m_fetch_pc);
        chk("v_o", {31'b0, s_v}, {31'b0, e_v});
        if (e_v) begin
            chk("pc_o", s_pc, q[0].pc);
            chk("inst_o", s_inst, q[0].inst);
        end
        m_req_prev  = e_req;
        m_addr_prev = m_fetch_pc;
        if (r || b) begin
            q.delete();
            m_inflight = 1'b0;
            m_fetch_pc = r ? RST_PC : ba;
        end else begin
            if (e_v && !st) void'(q.pop_front());
            if (m_inflight && v_i) q.push_back('{pc: m_inflight_pc, inst: inst_i});
            if (e_req) begin
                m_inflight    = 1'b1;
                m_inflight_pc = m_fetch_pc;
                m_fetch_pc    = m_fetch_pc + 1;
            end else begin
                m_inflight = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[13];
    logic [31:0] got[4];
    logic [31:0] wrap_exp[4];
    logic        found;
    int          n;

    initial begin
        // Fill under stall from reset, then release: hand-derived cycle by cycle.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 32'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 32'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'd4, 1'b1, 32'd1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'd5, 1'b1, 32'd2};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'd6, 1'b1, 32'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'd7, 1'b1, 32'd4};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'd8, 1'b1, 32'd5};
        wrap_exp[0] = 32'hFFFF_FFFE;
        wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0001;

        rst = 1'b1; stall_i = 1'b1; branch_i = 1'b0; baddr_i = '0; v_i = 1'b0; inst_i = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, 1'b0, 32'd0, tbl[i].stall, 1'b0, 1'b0);
            chk("tbl_req", {31'b0, s_req}, {31'b0, tbl[i].req});
            if (tbl[i].req) chk("tbl_addr", s_addr, tbl[i].addr);
            chk("tbl_v", {31'b0, s_v}, {31'b0, tbl[i].v});
            if (tbl[i].v) chk("tbl_pc", s_pc, tbl[i].pc);
        end

        // Reset and stream: request in cycle 0, first output in cycle 2.
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("stream_req0", {31'b0, s_req}, 32'd1);
        chk("stream_addr0", s_addr, RST_PC);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("stream_v2", {31'b0, s_v}, 32'd1);
        chk("stream_pc2", s_pc, RST_PC);
        chk("stream_inst2", s_inst, RST_PC ^ KEY);

        // Branch with the response for address 7 in flight.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            if (s_req && s_addr == 32'd7) found = 1'b1;
        end
        chk("find_addr7", {31'b0, found}, 32'd1);
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("br_req", {31'b0, s_req}, 32'd1);
        chk("br_addr", s_addr, 32'h100);
        chk("br_v1", {31'b0, s_v}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("br_v2", {31'b0, s_v}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("br_v3", {31'b0, s_v}, 32'd1);
        chk("br_pc3", s_pc, 32'h100);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("br_pc4", s_pc, 32'h101);

        // Fill the buffer, then branch while the head is being consumed.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            if (s_v) begin
                found = 1'b1;
                chk("full_br_pc", s_pc, 32'h40);
            end
        end
        chk("full_br_seen", {31'b0, found}, 32'd1);

        // Address wrap, then a one-cycle reset pulse mid-stream.
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 12 && n < 4; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            if (s_v) begin
                got[n] = s_pc;
                n++;
            end
        end
        chk("wrap_count", n, 32'd4);
        for (int i = 0; i < 4; i++) chk("wrap_pc", got[i], wrap_exp[i]);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_req_held", {31'b0, s_req}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_v", {31'b0, s_v}, 32'd0);
        chk("rst_addr", s_addr, RST_PC);

        // Random traffic: stalls, redirects, resets, lost and spurious responses.
        for (int i = 0; i < 3000; i++) begin
            logic        r, b, st, drop, spur;
            logic [31:0] ba;
            r    = ($urandom_range(99) == 0);
            b    = !r && ($urandom_range(19) == 0);
            ba   = ($urandom_range(3) == 0) ? (32'hFFFF_FFFC + $urandom_range(3)) : $urandom;
            st   = ($urandom_range(2) == 0);
            drop = ($urandom_range(29) == 0);
            spur = ($urandom_range(9) == 0);
            step(r, b, ba, st, drop, spur);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
